lsu_mem_ctrl: RTL
=================

# lsu_mem_ctrl

Load/store initiator for the RV32I core's byte-enabled single-port data BRAM. The block accepts one load or store request at a time from the execute stage. It converts the RISC-V funct3 access size into BRAM byte enables and replicated store data, and sequences the BRAM's two-cycle registered read. It then returns sign- or zero-extended load data, and flags misaligned or illegal accesses without touching memory.

## Interface
Parameters:
- DEPTH, 4096: BRAM depth; ADDRWIDTH = $clog2(DEPTH) is a localparam.
- XLEN, 32: data width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3:
  - loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - stores: 0 SB, 1 SH, 2 SW.
- req_addr  in  32  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; misaligned or illegal funct3.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDRWIDTH  byte address req_addr[ADDRWIDTH-1:0]; the BRAM uses bits [ADDRWIDTH-1:2].
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_byte_we  out  4  per-byte write enables.
- mem_rdata  in  XLEN  BRAM registered read data.

## Operation
- FSM states: IDLE, WRITE, RADDR, RDATA, RESP.
- All outputs are registered or decoded from state/registered fields. After reset every output is 0 except req_ready = 1.
- On accept, the block latches we, funct3, addr and wdata, then checks legality:
  - Error cases:
    - funct3 not in the list for the request type;
    - LH/LHU/SH with addr[0] = 1;
    - LW/SW with addr[1:0] != 0.
  - On error: go to RESP with resp_err = 1, and mem_en never asserts.
  - Legal store: go to WRITE.
  - Legal load: go to RADDR.
- Store lane mapping (addr[1:0] = a):
  - SB: mem_wdata = {4{wdata[7:0]}}, mem_byte_we = 4'b0001 << a.
  - SH: mem_wdata = {2{wdata[15:0]}}, mem_byte_we = a[1] ? 4'b1100 : 4'b0011.
  - SW: mem_wdata = wdata, mem_byte_we = 4'b1111.
- WRITE: mem_en = mem_we = 1 for exactly one cycle, then RESP. The write commits at the edge leaving WRITE.
- RADDR: mem_en = 1, mem_we = 0, mem_byte_we = 0, mem_addr driven; the BRAM captures the address at the exiting edge.
- RDATA: mem_en = 1, mem_addr held; the BRAM loads mem_rdata at the exiting edge.
- RESP: mem_en = 0, so mem_rdata stays stable. resp_valid = 1, then the FSM returns to IDLE.
- Load extraction from mem_rdata, with byte b = bits [8a+7:8a] and half h = bits [16a[1]+15:16a[1]]:
  - LB: sign-extend b.
  - LBU: zero-extend b.
  - LH: sign-extend h.
  - LHU: zero-extend h.
  - LW: full word.
- mem_we and mem_byte_we are 0 in every state except WRITE.

## Timing
Cycle 0 is the accept edge.
- Store: WRITE in cycle 1, resp_valid in cycle 2; req_ready returns in cycle 3.
- Load: RADDR in cycle 1, RDATA in cycle 2, resp_valid with data in cycle 3; req_ready returns in cycle 4.
- Error: resp_valid in cycle 1.
- req_ready is low from the cycle after accept through RESP. Back-to-back requests are therefore spaced 3 (store) or 4 (load) cycles apart, and a held req_valid is accepted again in the first IDLE cycle.
- Request inputs are sampled only at the accept edge; changes afterwards are ignored.
- Reset mid-operation:
  - The FSM returns to IDLE immediately and all outputs clear asynchronously.
  - Reset asserted during WRITE before the edge prevents the write.
  - No resp_valid is issued for an aborted request.

## Test plan
- SW 0xDEADBEEF @0x010 -> cycle 1: mem_en = mem_we = 1, mem_byte_we = 1111, mem_wdata = 0xDEADBEEF. Cycle 2: resp_valid, resp_err = 0. Then LW @0x010 -> resp_valid in cycle 3 with 0xDEADBEEF.
- SB 0x00000080 @0x013 -> mem_byte_we = 1000, mem_wdata = 0x80808080. Then LB @0x013 -> 0xFFFFFF80, and LBU @0x013 -> 0x00000080.
- SH 0x0000F234 @0x012 -> mem_byte_we = 1100, mem_wdata = 0xF234F234. Then LH @0x012 -> 0xFFFFF234, and LHU -> 0x0000F234.
- LW @0x011, SH @0x001, and load funct3 = 3 -> each gives resp_valid in cycle 1 with resp_err = 1, resp_rdata = 0, and mem_en stays 0 throughout.
- req_valid held high with alternating load and store requests -> req_ready low during each operation, with no overlap of mem_en windows. Accept spacing is exactly 4 cycles after a load and 3 after a store.
- Assert rst in RDATA of a load, and separately in WRITE of SW 0x11111111 over existing 0xDEADBEEF -> outputs 0 immediately, req_ready = 1, no resp_valid. A later LW returns 0xDEADBEEF, proving the aborted write did not commit.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and BRAM-side signal bundle of the load/store unit.
// The slave modport is the LSU itself; the master modport is whatever
// surrounds it (execute stage on the request side, BRAM on the memory side).
interface lsu_mem_ctrl_if #(
  parameter int ADDRWIDTH = 12,
  parameter int XLEN      = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [2:0]           req_funct3;
  logic [31:0]          req_addr;
  logic [XLEN-1:0]      req_wdata;
  logic                 resp_valid;
  logic [XLEN-1:0]      resp_rdata;
  logic                 resp_err;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [XLEN-1:0]      mem_wdata;
  logic [3:0]           mem_byte_we;
  logic [XLEN-1:0]      mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_addr, mem_wdata, mem_byte_we
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_addr, mem_wdata, mem_byte_we
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a byte-enabled single-port BRAM with a two-stage
// registered read. One request in flight; illegal or misaligned accesses are
// answered with an error response and never reach the memory.
module lsu_mem_ctrl #(
  parameter int DEPTH = 4096,
  parameter int XLEN  = 32
) (
  input logic          clk,
  input logic          rst,
  lsu_mem_ctrl_if.slave bus
);
  localparam int ADDRWIDTH = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, WRITE, RADDR, RDATA, RESP} state_t;

  state_t               state_reg, state_next;
  logic                 we_reg;
  logic                 err_reg;
  logic [2:0]           funct3_reg;
  logic [ADDRWIDTH-1:0] addr_reg;
  logic [XLEN-1:0]      wdata_reg;

  logic                 accept;
  logic                 req_illegal;
  logic [XLEN-1:0]      store_wdata;
  logic [3:0]           store_byte_we;
  logic [7:0]           load_byte;
  logic [15:0]          load_half;
  logic [XLEN-1:0]      load_data;

  // Only the BRAM-visible address bits are kept; the rest are don't-care.
  wire unused_addr_bits = ^bus.req_addr[31:ADDRWIDTH];

  assign accept = bus.req_valid && (state_reg == IDLE);

  // Legality of the incoming request: funct3 must exist for the access type
  // and halfword/word accesses must be naturally aligned.
  always_comb begin
    req_illegal = 1'b0;
    case (bus.req_funct3)
      3'd0:    req_illegal = 1'b0;
      3'd1:    req_illegal = bus.req_addr[0];
      3'd2:    req_illegal = |bus.req_addr[1:0];
      3'd4:    req_illegal = bus.req_we;
      3'd5:    req_illegal = bus.req_we | bus.req_addr[0];
      default: req_illegal = 1'b1;
    endcase
  end

  // State register and request capture; async reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      we_reg     <= 1'b0;
      err_reg    <= 1'b0;
      funct3_reg <= 3'd0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg     <= bus.req_we;
        err_reg    <= req_illegal;
        funct3_reg <= bus.req_funct3;
        addr_reg   <= bus.req_addr[ADDRWIDTH-1:0];
        wdata_reg  <= bus.req_wdata;
      end
    end
  end

  // Next-state sequencing: store takes one memory cycle, load takes two.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_illegal)      state_next = RESP;
          else if (bus.req_we)  state_next = WRITE;
          else                  state_next = RADDR;
        end
      end
      WRITE:   state_next = RESP;
      RADDR:   state_next = RDATA;
      RDATA:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Store lane replication and byte enables from the latched size/offset.
  always_comb begin
    store_wdata   = wdata_reg;
    store_byte_we = 4'b1111;
    case (funct3_reg[1:0])
      2'd0: begin
        store_wdata   = {4{wdata_reg[7:0]}};
        store_byte_we = 4'b0001 << addr_reg[1:0];
      end
      2'd1: begin
        store_wdata   = {2{wdata_reg[15:0]}};
        store_byte_we = addr_reg[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_wdata   = wdata_reg;
        store_byte_we = 4'b1111;
      end
    endcase
  end

  // Lane selection and sign/zero extension of the BRAM read word.
  always_comb begin
    load_byte = bus.mem_rdata[7:0];
    case (addr_reg[1:0])
      2'd0:    load_byte = bus.mem_rdata[7:0];
      2'd1:    load_byte = bus.mem_rdata[15:8];
      2'd2:    load_byte = bus.mem_rdata[23:16];
      default: load_byte = bus.mem_rdata[31:24];
    endcase
    load_half = addr_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_reg)
      3'd0:    load_data = {{24{load_byte[7]}}, load_byte};
      3'd4:    load_data = {24'd0, load_byte};
      3'd1:    load_data = {{16{load_half[15]}}, load_half};
      3'd5:    load_data = {16'd0, load_half};
      default: load_data = bus.mem_rdata;
    endcase
  end

  // Output decode: everything is a function of state and latched fields,
  // and write-side signals are only non-zero while in WRITE.
  always_comb begin
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_err    = 1'b0;
    bus.resp_rdata  = '0;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_byte_we = 4'b0000;
    case (state_reg)
      IDLE:  bus.req_ready = 1'b1;
      WRITE: begin
        bus.mem_en      = 1'b1;
        bus.mem_we      = 1'b1;
        bus.mem_addr    = addr_reg;
        bus.mem_wdata   = store_wdata;
        bus.mem_byte_we = store_byte_we;
      end
      RADDR, RDATA: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = addr_reg;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_reg;
        bus.resp_rdata = (we_reg || err_reg) ? '0 : load_data;
      end
      default: ;
    endcase
  end
endmodule
